// File: rtl/gt_int_serial_seq.sv
// Bit-serial signed greater-than comparator: one bit pair per cycle, LSB first.
// Handshake accepted in IDLE only; the result is held in DONE until out_ready.
module gt_int_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             gt_q;
  logic             y_q;
  logic             last_bit;
  logic             gt_nxt;

  assign last_bit = (cnt_q == LAST);

  // The sign bit carries inverted weight: a set sign bit on A means A is smaller.
  always_comb begin
    gt_nxt = gt_q;
    if (a_q[0] != b_q[0]) begin
      gt_nxt = last_bit ? b_q[0] : a_q[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_bit)  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
  end

  // Shift registers are not reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      gt_q  <= 1'b0;
      y_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            cnt_q <= '0;
            gt_q  <= 1'b0;
          end
        end
        S_RUN: begin
          a_q  <= a_q >> 1;
          b_q  <= b_q >> 1;
          gt_q <= gt_nxt;
          if (last_bit) begin
            y_q <= gt_nxt;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_gt_int_serial_seq.sv
// Bench for gt_int_serial_seq: vector table plus reset/backpressure sequences.
module tb_gt_int_serial_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] A, B;
  logic         in_ready, out_valid, Y, busy;

  gt_int_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         exp;
  } vec_t;

  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   expq[$];

  task automatic chk(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // junk=1 keeps in_valid high and scrambles A/B after the handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic exp, input int hold, input bit junk);
    int  t;
    logic y0;
    t = 0;
    while (!in_ready && t < 100) begin
      step();
      t++;
    end
    chk("ready_before_hs", in_ready, 1'b1);
    A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
    expq.push_back(exp);
    step();
    if (!junk) in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      chk("busy_in_run", busy, 1'b1);
      chk("no_ready_in_run", in_ready, 1'b0);
      chk("no_valid_in_run", out_valid, 1'b0);
      if (junk) begin
        A = $urandom; B = $urandom;
      end
      step();
    end
    chk("out_valid_latency", out_valid, 1'b1);
    chk("busy_done", busy, 1'b0);
    if (expq.size() > 0) begin
      chk("Y_result", Y, expq.pop_front());
    end else begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end
    y0 = Y;
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        A = $urandom; B = $urandom;
      end
      step();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_Y", Y, y0);
      chk("hold_no_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    chk("no_same_cycle_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_no_valid", out_valid, 1'b0);
  endtask

  initial begin
    tbl[0] = '{32'd5,        32'd3,        1'b1};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[2] = '{32'h00000000, 32'hFFFFFFFF, 1'b1};
    tbl[3] = '{32'h7FFFFFFF, 32'h80000000, 1'b1};
    tbl[4] = '{32'h80000000, 32'h7FFFFFFF, 1'b0};
    tbl[5] = '{32'h12345678, 32'h12345678, 1'b0};
    tbl[6] = '{32'd3,        32'd5,        1'b0};
    tbl[7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
    tbl[8] = '{32'h80000000, 32'h80000001, 1'b0};
    tbl[9] = '{32'd1,        32'd0,        1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_Y", Y, 1'b0);
    rst = 1'b0;
    step();
    chk("idle_hold_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp, (i == 4) ? 10 : i % 3, i == 2);
    end

    // Mid-run reset after a Y=1 result so a cleared Y is observable.
    run_op(32'd5, 32'd3, 1'b1, 0, 1'b0);
    A = 32'd9; B = 32'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_Y", Y, 1'b0);
    for (int k = 0; k < W + 4; k++) begin
      step();
      if (k == W + 3) chk("midrst_no_result", out_valid, 1'b0);
    end
    run_op(32'hFFFFFF00, 32'hFFFFFFF0, 1'b0, 1, 1'b0);
    run_op(32'd100, 32'hFFFFFF9C, 1'b1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = (i == 3) ? ra : $urandom;
      run_op(ra, rb, $signed(ra) > $signed(rb), i % 2, i == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/gt_int_serial_seq.md
GT_INT_SERIAL_SEQ -- requirements
Module: gt_int_serial_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal range 2..64.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: synchronous active-high reset.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the operand pair on A/B is valid.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept an operand pair.
REQ-007 Port A SHALL be an input, WIDTH bits wide: signed two's-complement operand A.
REQ-008 Port B SHALL be an input, WIDTH bits wide: signed two's-complement operand B.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: Y holds a completed result.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts Y.
REQ-011 Port Y SHALL be an output, 1 bit wide: 1 iff signed A > signed B.
REQ-012 Port busy SHALL be an output, 1 bit wide: high in RUN state.

Function
REQ-013 The block SHALL implement the states IDLE, RUN and DONE, held in a registered state variable.
REQ-014 in_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be 1 exactly in RUN; out_valid SHALL be 1 exactly in DONE.
REQ-015 Handshake: in IDLE with in_valid=1, the edge SHALL capture A and B into internal shift registers, clear the bit counter to 0 and the gt flag to 0, and enter RUN.
REQ-016 In IDLE with in_valid=0, the block SHALL hold all state.
REQ-017 In RUN, each cycle SHALL process one bit pair (a_i, b_i) LSB-first, where i equals the counter value; the shift registers shift right by one and the counter increments.
REQ-018 For bits i < WIDTH-1 with a_i != b_i, the gt flag SHALL become a_i; if a_i == b_i, it SHALL hold.
REQ-019 For sign bit i = WIDTH-1 with a_i != b_i, the gt flag SHALL become b_i (inverted sense); if a_i == b_i, it SHALL hold.
REQ-020 On the edge that processes bit WIDTH-1, the block SHALL register the final gt flag into Y and enter DONE.
REQ-021 Latency: if the handshake occurs in cycle c, RUN SHALL occupy cycles c+1..c+WIDTH and out_valid SHALL first be high in cycle c+WIDTH+1.
REQ-022 Equal operands SHALL yield Y=0.
REQ-023 In DONE, Y and out_valid SHALL hold stable while out_ready=0, with no cycle limit.
REQ-024 In DONE with out_ready=1, the block SHALL return to IDLE on that edge; in_ready first rises in the following cycle, so there is no same-cycle accept.
REQ-025 in_valid and A/B changes during RUN or DONE SHALL be ignored.
REQ-026 The counter SHALL be clog2(WIDTH) bits wide and SHALL never wrap within an operation.

Reset
REQ-027 When rst=1 at an edge, the block SHALL, with priority over all other events, set state=IDLE, counter=0, gt flag=0, Y=0, out_valid=0, busy=0, in_ready=1.
REQ-028 Reset during RUN or DONE SHALL discard the operation in progress and produce no result.
REQ-029 Shift-register contents after reset SHALL be don't-care, but SHALL NOT be visible on any output.

Verification (WIDTH=32; handshake in cycle c)
REQ-030 A=5, B=3 -> busy high for cycles c+1..c+32; out_valid=1 and Y=1 at c+33.
REQ-031 A=0xFFFFFFFF (-1), B=0x00000000 -> Y=0 at c+33; swapping the operands -> Y=1.
REQ-032 A=0x7FFFFFFF, B=0x80000000 -> Y=1; A=B=0x12345678 -> Y=0.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid rises -> Y and out_valid stay stable and in_ready stays 0; out_ready=1 -> IDLE next cycle and in_ready=1 the cycle after.
REQ-034 Assert rst at cycle c+11 (mid-RUN) -> next cycle in_ready=1, busy=0, out_valid=0, Y=0; a new handshake then completes normally with correct Y.
REQ-035 Drive in_valid=1 continuously with changing A/B during RUN -> only the captured pair affects Y; the next pair is accepted only in IDLE.
